// File: rtl/lfsr_decrypt_seq_if.sv
// DM-port and req/ack bundle between top_level and the decrypt sequencer.
// master: top_level side (drives req, mem_rdata); slave: the sequencer.
interface lfsr_decrypt_seq_if;
    logic       req;
    logic       ack;
    logic       busy;
    logic [6:0] mem_addr;
    logic       mem_wr_en;
    logic [7:0] mem_wdata;
    logic [7:0] mem_rdata;
    logic       err;
    logic [3:0] ptrn_idx;
    logic [6:0] par_err_cnt;

    modport master (
        output req,
        output mem_rdata,
        input  ack,
        input  busy,
        input  mem_addr,
        input  mem_wr_en,
        input  mem_wdata,
        input  err,
        input  ptrn_idx,
        input  par_err_cnt
    );

    modport slave (
        input  req,
        input  mem_rdata,
        output ack,
        output busy,
        output mem_addr,
        output mem_wr_en,
        output mem_wdata,
        output err,
        output ptrn_idx,
        output par_err_cnt
    );
endinterface

// File: rtl/lfsr_decrypt_seq.sv
// Program-2 decrypt sequencer: recovers LFSR seed/taps from the space
// preamble at DM[ENC_BASE..], writes plaintext to DM[PLAIN_BASE..].
// Ports: clk, init (sync active-high reset), bus (slave modport):
//   req/ack handshake, busy, DM port (mem_addr, mem_wr_en, mem_wdata,
//   mem_rdata with 1-cycle read latency), err, ptrn_idx, par_err_cnt.
module lfsr_decrypt_seq #(
    parameter logic [6:0] ENC_BASE   = 7'd64,
    parameter logic [6:0] PLAIN_BASE = 7'd0,
    parameter int         MSG_LEN    = 64,
    parameter int         PROBE_LEN  = 10
) (
    input  logic              clk,
    input  logic              init,
    lfsr_decrypt_seq_if.slave bus
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_SEARCH,
        S_DEC_RD,
        S_DEC_WR,
        S_DONE
    } state_t;

    localparam logic [6:0] LAST_RD  = 7'(PROBE_LEN - 1);
    localparam logic [6:0] LOAD_END = 7'(PROBE_LEN);
    localparam logic [3:0] LAST_J   = 4'(PROBE_LEN - 1);
    localparam logic [3:0] LAST_K   = 4'd8;
    localparam logic [6:0] LAST_I   = 7'(MSG_LEN - 1);

    function automatic logic [6:0] f_tap(input logic [3:0] k);
        case (k)
            4'd0:    f_tap = 7'h60;
            4'd1:    f_tap = 7'h48;
            4'd2:    f_tap = 7'h78;
            4'd3:    f_tap = 7'h72;
            4'd4:    f_tap = 7'h6A;
            4'd5:    f_tap = 7'h69;
            4'd6:    f_tap = 7'h5C;
            4'd7:    f_tap = 7'h7E;
            4'd8:    f_tap = 7'h7B;
            default: f_tap = 7'h60;
        endcase
    endfunction

    function automatic logic [6:0] f_step(
        input logic [6:0] s,
        input logic [6:0] t
    );
        f_step = {s[5:0], ^(s & t)};
    endfunction

    state_t     r_state;
    logic       r_ack;
    logic       r_busy;
    logic       r_wr;
    logic       r_err;
    logic [3:0] r_idx;
    logic [6:0] r_par;
    logic [6:0] r_addr;
    logic [6:0] r_cnt;
    logic [3:0] r_j;
    logic [3:0] r_k;
    logic [6:0] r_s;
    logic [6:0] r_p [PROBE_LEN];

    logic [6:0] w_seed;
    logic [6:0] w_nxt_srch;
    logic [6:0] w_nxt_dec;
    logic [7:0] w_plain;
    logic       w_par_bad;

    // An all-zero seed would lock the LFSR at zero.
    assign w_seed     = (r_p[0] == 7'd0) ? 7'h01 : r_p[0];
    assign w_nxt_srch = f_step(r_s, f_tap(r_k));
    assign w_nxt_dec  = f_step(r_s, f_tap(r_idx));
    assign w_plain    = {1'b0, bus.mem_rdata[6:0] ^ r_s};
    assign w_par_bad  = bus.mem_rdata[7] != ^bus.mem_rdata[6:0];

    assign bus.ack         = r_ack;
    assign bus.busy        = r_busy;
    assign bus.mem_addr    = r_addr;
    assign bus.mem_wr_en   = r_wr;
    assign bus.err         = r_err;
    assign bus.ptrn_idx    = r_idx;
    assign bus.par_err_cnt = r_par;
    // Read data only arrives in DEC_WR, so write data follows it directly.
    assign bus.mem_wdata   = (r_state == S_DEC_WR) ? w_plain : 8'h00;

    always_ff @(posedge clk) begin
        if (init) begin
            r_state <= S_IDLE;
            r_ack   <= 1'b0;
            r_busy  <= 1'b0;
            r_wr    <= 1'b0;
            r_err   <= 1'b0;
            r_idx   <= 4'd0;
            r_par   <= 7'd0;
            r_addr  <= 7'd0;
            r_cnt   <= 7'd0;
            r_j     <= 4'd0;
            r_k     <= 4'd0;
            r_s     <= 7'd0;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (bus.req) begin
                        r_state <= S_LOAD;
                        r_busy  <= 1'b1;
                        r_err   <= 1'b0;
                        r_idx   <= 4'd0;
                        r_par   <= 7'd0;
                        r_addr  <= ENC_BASE;
                        r_cnt   <= 7'd0;
                        r_j     <= 4'd0;
                    end
                end
                S_LOAD: begin
                    // Reads issue on cnt 0..9, data lands on cnt 1..10.
                    if (r_cnt < LAST_RD)
                        r_addr <= ENC_BASE + r_cnt + 7'd1;
                    if (r_cnt != 7'd0) begin
                        r_p[r_j] <= bus.mem_rdata[6:0] ^ 7'h20;
                        r_j      <= r_j + 4'd1;
                    end
                    r_cnt <= r_cnt + 7'd1;
                    if (r_cnt == LOAD_END) begin
                        r_state <= S_SEARCH;
                        r_k     <= 4'd0;
                        r_j     <= 4'd1;
                        r_s     <= w_seed;
                    end
                end
                S_SEARCH: begin
                    if (w_nxt_srch == r_p[r_j]) begin
                        if (r_j == LAST_J) begin
                            r_idx   <= r_k;
                            r_state <= S_DEC_RD;
                            r_addr  <= ENC_BASE;
                            r_cnt   <= 7'd0;
                            r_s     <= w_seed;
                        end else begin
                            r_s <= w_nxt_srch;
                            r_j <= r_j + 4'd1;
                        end
                    end else if (r_k == LAST_K) begin
                        r_err   <= 1'b1;
                        r_ack   <= 1'b1;
                        r_busy  <= 1'b0;
                        r_state <= S_DONE;
                    end else begin
                        r_k <= r_k + 4'd1;
                        r_j <= 4'd1;
                        r_s <= w_seed;
                    end
                end
                S_DEC_RD: begin
                    r_state <= S_DEC_WR;
                    r_addr  <= PLAIN_BASE + r_cnt;
                    r_wr    <= 1'b1;
                end
                S_DEC_WR: begin
                    r_wr <= 1'b0;
                    r_s  <= w_nxt_dec;
                    if (w_par_bad && r_par != 7'h7F)
                        r_par <= r_par + 7'd1;
                    if (r_cnt == LAST_I) begin
                        r_state <= S_DONE;
                        r_ack   <= 1'b1;
                        r_busy  <= 1'b0;
                    end else begin
                        r_cnt   <= r_cnt + 7'd1;
                        r_addr  <= ENC_BASE + r_cnt + 7'd1;
                        r_state <= S_DEC_RD;
                    end
                end
                S_DONE: begin
                    if (!bus.req) begin
                        r_state <= S_IDLE;
                        r_ack   <= 1'b0;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_lfsr_decrypt_seq.sv
// Bench for lfsr_decrypt_seq: DM model, encryptor, reference decryptor.
// Table vectors, an init-abort sequence and randomized runs per tap.
module tb_lfsr_decrypt_seq;

    logic clk = 1'b0;
    logic init;
    logic clr;

    always #5 clk = ~clk;

    lfsr_decrypt_seq_if bus ();

    lfsr_decrypt_seq dut (
        .clk  (clk),
        .init (init),
        .bus  (bus)
    );

    logic [7:0] enc_img [64];
    logic [7:0] dm_lo   [64];
    logic [7:0] exp_lo  [64];
    int         n_wr = 0;
    int         nchk = 0;
    int         nerr = 0;

    logic [6:0] TAPS [9] = '{7'h60, 7'h48, 7'h78, 7'h72, 7'h6A,
                             7'h69, 7'h5C, 7'h7E, 7'h7B};
    string MSG = "Knowledge comes, but wisdom lingers";

    // DM: upper half holds the ciphertext image, lower half the output.
    always @(posedge clk) begin
        bus.mem_rdata <= bus.mem_addr[6] ? enc_img[bus.mem_addr[5:0]]
                                         : dm_lo[bus.mem_addr[5:0]];
        if (clr) begin
            for (int i = 0; i < 64; i++) dm_lo[i] <= 8'hEE;
        end else if (bus.mem_wr_en === 1'b1) begin
            if (!bus.mem_addr[6]) dm_lo[bus.mem_addr[5:0]] <= bus.mem_wdata;
            n_wr <= n_wr + 1;
        end
    end

    function automatic logic [6:0] lstep(input logic [6:0] s,
                                         input logic [6:0] t);
        return {s[5:0], ^(s & t)};
    endfunction

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic chk_le(input string nm, input int act, input int lim);
        nchk++;
        if (act > lim) begin
            nerr++;
            $display("FAIL %s: got %0d expected <= %0d", nm, act, lim);
        end
    endtask

    task automatic build(input int tap, input logic [6:0] ini,
                         input int plen, input bit rnd);
        logic [6:0] s, c, ch;
        byte b;
        s = ini;
        for (int i = 0; i < 64; i++) begin
            if (i < plen) ch = 7'h20;
            else if (rnd) ch = 7'($urandom_range(32, 126));
            else if (i - plen < MSG.len()) begin
                b = MSG[i - plen];
                ch = b[6:0];
            end else ch = 7'h20;
            c = ch ^ s;
            enc_img[i] = {^c, c};
            s = lstep(s, TAPS[tap]);
        end
    endtask

    // Try every tap in order against the preamble, then decrypt.
    task automatic ref_model(output bit e, output int idx, output int par);
        logic [6:0] p [10];
        logic [6:0] seed, s;
        bit ok;
        for (int j = 0; j < 10; j++) p[j] = enc_img[j][6:0] ^ 7'h20;
        seed = (p[0] == 7'd0) ? 7'h01 : p[0];
        e = 1'b1;
        idx = 0;
        par = 0;
        for (int k = 0; k < 9 && e; k++) begin
            s = seed;
            ok = 1'b1;
            for (int j = 1; j < 10; j++) begin
                s = lstep(s, TAPS[k]);
                if (s != p[j]) ok = 1'b0;
            end
            if (ok) begin
                e = 1'b0;
                idx = k;
            end
        end
        s = seed;
        for (int i = 0; i < 64; i++) begin
            if (e) exp_lo[i] = 8'hEE;
            else begin
                exp_lo[i] = {1'b0, enc_img[i][6:0] ^ s};
                if (enc_img[i][7] != ^enc_img[i][6:0]) par++;
            end
            s = lstep(s, TAPS[idx]);
        end
    endtask

    task automatic clr_mem();
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        @(negedge clk);
    endtask

    task automatic run_once(input int drop_at, input bit hold,
                            output int lat, output int ackw);
        bus.req = 1'b1;
        lat = 0;
        ackw = 0;
        while (bus.ack !== 1'b1 && lat < 300) begin
            @(negedge clk);
            lat++;
            if (lat == drop_at) bus.req = 1'b0;
        end
        chk("ack_seen", 32'(bus.ack), 1);
        if (bus.ack === 1'b1) begin
            ackw = 1;
            if (hold) begin
                repeat (5) begin
                    @(negedge clk);
                    if (bus.ack === 1'b1) ackw++;
                end
            end
            bus.req = 1'b0;
            repeat (4) begin
                @(negedge clk);
                if (bus.ack === 1'b1) ackw++;
            end
        end
        bus.req = 1'b0;
        chk("busy_idle", 32'(bus.busy), 0);
    endtask

    task automatic verify(input string tag, input int w0, input int lat);
        bit e;
        int idx, par, score;
        ref_model(e, idx, par);
        chk({tag, "_err"}, 32'(bus.err), 32'(e));
        chk({tag, "_ptrn_idx"}, 32'(bus.ptrn_idx), idx);
        chk({tag, "_par_err_cnt"}, 32'(bus.par_err_cnt), par);
        chk({tag, "_writes"}, n_wr - w0, e ? 0 : 64);
        score = 0;
        for (int i = 0; i < 64; i++)
            if (dm_lo[i] === exp_lo[i]) score++;
        chk({tag, "_score"}, score, 64);
        chk_le({tag, "_latency"}, lat, 222);
    endtask

    typedef struct {
        int         tap;
        logic [6:0] ini;
        int         plen;
        bit         flip;
        bit         corrupt;
        int         drop;
        bit         hold;
        bit         exp_err;
        int         exp_idx;
        int         exp_par;
        bit         chk_lat;
    } vec_t;

    vec_t tbl [5];

    initial begin
        int lat, ackw, w0, w1;
        logic [6:0] ini;
        int plen;

        tbl[0] = '{0, 7'h01, 10, 1'b0, 1'b0, 0, 1'b0, 1'b0, 0, 0, 1'b1};
        tbl[1] = '{0, 7'h01, 10, 1'b1, 1'b0, 0, 1'b0, 1'b0, 0, 2, 1'b0};
        tbl[2] = '{0, 7'h01, 10, 1'b0, 1'b1, 0, 1'b0, 1'b1, -1, 0, 1'b0};
        tbl[3] = '{4, 7'h33, 12, 1'b0, 1'b0, 14, 1'b0, 1'b0, -1, 0, 1'b0};
        tbl[4] = '{7, 7'h5A, 10, 1'b0, 1'b0, 0, 1'b1, 1'b0, -1, 0, 1'b0};

        init = 1'b1;
        clr = 1'b0;
        bus.req = 1'b0;
        for (int i = 0; i < 64; i++) enc_img[i] = 8'h00;
        repeat (3) @(negedge clk);
        chk("rst_ack", 32'(bus.ack), 0);
        chk("rst_busy", 32'(bus.busy), 0);
        chk("rst_wr_en", 32'(bus.mem_wr_en), 0);
        chk("rst_err", 32'(bus.err), 0);
        chk("rst_ptrn_idx", 32'(bus.ptrn_idx), 0);
        chk("rst_par", 32'(bus.par_err_cnt), 0);
        chk("rst_addr", 32'(bus.mem_addr), 0);
        chk("rst_wdata", 32'(bus.mem_wdata), 0);
        init = 1'b0;
        @(negedge clk);

        for (int v = 0; v < 5; v++) begin
            build(tbl[v].tap, tbl[v].ini, tbl[v].plen, 1'b0);
            if (tbl[v].flip) begin
                enc_img[36][7] = ~enc_img[36][7];
                enc_img[37][7] = ~enc_img[37][7];
            end
            if (tbl[v].corrupt)
                for (int i = 0; i < 10; i++) enc_img[i] = 8'h55;
            clr_mem();
            w0 = n_wr;
            run_once(tbl[v].drop, tbl[v].hold, lat, ackw);
            verify($sformatf("vec%0d", v), w0, lat);
            chk($sformatf("vec%0d_exp_err", v), 32'(bus.err),
                32'(tbl[v].exp_err));
            chk($sformatf("vec%0d_exp_par", v), 32'(bus.par_err_cnt),
                tbl[v].exp_par);
            if (tbl[v].exp_idx >= 0)
                chk($sformatf("vec%0d_exp_idx", v), 32'(bus.ptrn_idx),
                    tbl[v].exp_idx);
            chk($sformatf("vec%0d_ack_width", v), ackw,
                tbl[v].hold ? 6 : 1);
            if (tbl[v].chk_lat) begin
                chk_le($sformatf("vec%0d_lat_hi", v), lat, 151);
                chk_le($sformatf("vec%0d_lat_lo", v), 149, lat);
            end
        end

        // init during the decrypt phase, then a clean rerun.
        build(0, 7'h2B, 10, 1'b0);
        clr_mem();
        bus.req = 1'b1;
        repeat (81) @(negedge clk);
        chk("abort_busy_before", 32'(bus.busy), 1);
        init = 1'b1;
        bus.req = 1'b0;
        @(negedge clk);
        chk("abort_ack", 32'(bus.ack), 0);
        chk("abort_busy", 32'(bus.busy), 0);
        chk("abort_wr_en", 32'(bus.mem_wr_en), 0);
        chk("abort_err", 32'(bus.err), 0);
        chk("abort_ptrn_idx", 32'(bus.ptrn_idx), 0);
        chk("abort_par", 32'(bus.par_err_cnt), 0);
        chk("abort_addr", 32'(bus.mem_addr), 0);
        chk("abort_wdata", 32'(bus.mem_wdata), 0);
        w1 = n_wr;
        @(negedge clk);
        init = 1'b0;
        repeat (10) @(negedge clk);
        chk("abort_no_writes", n_wr - w1, 0);
        clr_mem();
        w0 = n_wr;
        run_once(0, 1'b0, lat, ackw);
        verify("rerun", w0, lat);

        for (int t = 0; t < 9; t++) begin
            ini = 7'($urandom_range(1, 127));
            plen = $urandom_range(10, 26);
            build(t, ini, plen, 1'b1);
            clr_mem();
            w0 = n_wr;
            run_once(0, 1'b0, lat, ackw);
            verify($sformatf("rnd_tap%0d", t), w0, lat);
            chk($sformatf("rnd_tap%0d_ack_width", t), ackw, 1);
        end

        $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
        $finish;
    end

endmodule
